// File: rtl/rr_arbiter_4_1.sv
// rr_arbiter_4_1: round-robin 4:1 mux sequencer with bounded bursts and valid/ready output
module rr_arbiter_4_1 #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [3:0]       req_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             ready_i,
  output logic [3:0]       gnt_o,
  output logic [1:0]       sel_o,
  output logic [WIDTH-1:0] f_o,
  output logic             valid_o
);
  typedef enum logic {IDLE, GRANT} state_e;
  state_e     state_q;
  logic [1:0] sel_q, last_q, base, win, idx;
  logic [3:0] gnt_q, cnt_q;
  logic       found, xfer, rel, busy;
  assign busy    = state_q == GRANT;
  assign valid_o = busy && req_i[sel_q];
  assign xfer    = valid_o && ready_i;
  assign rel     = busy && (!req_i[sel_q] || (xfer && cnt_q == 4'(MAX_BURST - 1)));
  assign gnt_o   = gnt_q;
  assign sel_o   = sel_q;
  // selected word, forced to zero outside a grant
  always_comb begin
    f_o = !busy ? '0 : sel_q == 2'd0 ? a_i : sel_q == 2'd1 ? b_i : sel_q == 2'd2 ? c_i : d_i;
  end
  // rotating priority search starting after the previous owner (releasing index while granted)
  always_comb begin
    base  = busy ? sel_q : last_q;
    found = 1'b0;
    win   = base;
    idx   = base;
    for (int k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end
  // grant FSM: pick a winner when idle or on release, otherwise count accepted beats
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= 4'd0;
    end else if (!busy || rel) begin
      if (busy) last_q <= sel_q;
      cnt_q <= 4'd0;
      if (found) begin
        state_q <= GRANT;
        sel_q   <= win;
        gnt_q   <= 4'b0001 << win;
      end else begin
        state_q <= IDLE;
        gnt_q   <= 4'b0000;
      end
    end else if (xfer) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end
endmodule

// File: tb/tb_rr_arbiter_4_1.sv
// tb_rr_arbiter_4_1: table-driven directed checks of the round-robin arbiter
module tb_rr_arbiter_4_1;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] a, b, c, d;
  logic       ready;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic [7:0] f;
  logic       valid;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [3:0] req;
    logic       ready;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       chk_sel;
    logic       valid;
    logic [7:0] f;
  } vec_t;
  vec_t vecs[$];
  rr_arbiter_4_1 #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .a_i(a), .b_i(b), .c_i(c), .d_i(d),
    .ready_i(ready), .gnt_o(gnt), .sel_o(sel), .f_o(f), .valid_o(valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_out(input string tag, input logic [3:0] eg, input logic [1:0] es, input logic cs, input logic ev, input logic [7:0] ef);
    chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
    if (cs) chk({tag, ".sel"}, 32'(sel), 32'(es));
    chk({tag, ".valid"}, 32'(valid), 32'(ev));
    chk({tag, ".f"}, 32'(f), 32'(ef));
  endtask
  task automatic add(input logic [3:0] r, input logic rd, input logic [3:0] g, input logic [1:0] s, input logic cs, input logic v, input logic [7:0] ff, input int n);
    vec_t t;
    t = '{req: r, ready: rd, gnt: g, sel: s, chk_sel: cs, valid: v, f: ff};
    for (int i = 0; i < n; i++) vecs.push_back(t);
  endtask
  initial begin
    a = 8'h08; b = 8'h11; c = 8'h22; d = 8'h33;
    rst_n = 1'b0; req = 4'b1111; ready = 1'b1;
    // full contention: 4 beats each in order, then wrap to requester 0
    add(4'hF, 1, 4'h0, 0, 1, 0, 8'h00, 1);
    add(4'hF, 1, 4'h1, 0, 1, 1, 8'h08, 4);
    add(4'hF, 1, 4'h2, 1, 1, 1, 8'h11, 4);
    add(4'hF, 1, 4'h4, 2, 1, 1, 8'h22, 4);
    add(4'hF, 1, 4'h8, 3, 1, 1, 8'h33, 4);
    add(4'hF, 1, 4'h1, 0, 1, 1, 8'h08, 1);
    // single requester: re-granted on every burst boundary without a bubble
    add(4'h1, 1, 4'h1, 0, 1, 1, 8'h08, 5);
    add(4'h3, 1, 4'h1, 0, 1, 1, 8'h08, 2);
    // backpressure on requester 1: one beat, 5 stalled cycles, then 3 more beats
    add(4'h3, 1, 4'h2, 1, 1, 1, 8'h11, 1);
    add(4'h3, 0, 4'h2, 1, 1, 1, 8'h11, 5);
    add(4'h3, 1, 4'h2, 1, 1, 1, 8'h11, 3);
    // drop: requester 0 drops, 2 gets 2 beats and drops, 3 takes over then drops to idle
    add(4'hC, 1, 4'h1, 0, 1, 0, 8'h08, 1);
    add(4'hC, 1, 4'h4, 2, 1, 1, 8'h22, 2);
    add(4'h8, 1, 4'h4, 2, 1, 0, 8'h22, 1);
    add(4'h8, 1, 4'h8, 3, 1, 1, 8'h33, 1);
    add(4'h0, 1, 4'h8, 3, 1, 0, 8'h33, 1);
    add(4'h0, 1, 4'h0, 0, 0, 0, 8'h00, 1);
    add(4'h6, 1, 4'h0, 0, 0, 0, 8'h00, 1);
    add(4'h6, 1, 4'h2, 1, 1, 1, 8'h11, 1);
    @(negedge clk); #1;
    chk_out("reset", 4'h0, 2'd0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_n = 1'b1;
      req   = vecs[i].req;
      ready = vecs[i].ready;
      #1;
      chk_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].chk_sel, vecs[i].valid, vecs[i].f);
    end
    // requester 1 drops, requester 3 wins; reset asynchronously on its second beat
    @(negedge clk); req = 4'h8; #1;
    chk_out("hand_drop1", 4'h2, 2'd1, 1'b1, 1'b0, 8'h11);
    @(negedge clk); #1;
    chk_out("hand_beat1", 4'h8, 2'd3, 1'b1, 1'b1, 8'h33);
    @(negedge clk); #1;
    chk_out("hand_beat2", 4'h8, 2'd3, 1'b1, 1'b1, 8'h33);
    #1 rst_n = 1'b0; #1;
    chk_out("async_rst", 4'h0, 2'd0, 1'b1, 1'b0, 8'h00);
    @(negedge clk); req = 4'h9; #1;
    chk_out("rst_held", 4'h0, 2'd0, 1'b1, 1'b0, 8'h00);
    rst_n = 1'b1; #1;
    chk_out("rst_rel", 4'h0, 2'd0, 1'b1, 1'b0, 8'h00);
    @(negedge clk); #1;
    chk_out("post_rst", 4'h1, 2'd0, 1'b1, 1'b1, 8'h08);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
